// File: rtl/smips_pkg.sv
// Shared encodings for the smips multi-cycle control path:
// opcodes, functs, ALU controls, PC sources and FSM states.
package smips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_JUMP   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

endpackage

// File: rtl/smips_alu_decoder.sv
// R-type funct to ALU control decode, flagging functs the datapath
// cannot execute.
module smips_alu_decoder
    import smips_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_ctrl,
    output logic       o_funct_illegal
);

    always_comb begin
        o_alu_ctrl      = ALU_ADD;
        o_funct_illegal = 1'b0;
        case (i_funct)
            FN_ADD:  o_alu_ctrl = ALU_ADD;
            FN_SUB:  o_alu_ctrl = ALU_SUB;
            FN_AND:  o_alu_ctrl = ALU_AND;
            FN_OR:   o_alu_ctrl = ALU_OR;
            FN_SLT:  o_alu_ctrl = ALU_SLT;
            default: o_funct_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/smips_mc_ctrl.sv
// Multi-cycle control sequencer for the smips datapath.
// Define SMIPS_MEM_WAIT_EN to add the mem_ready wait-state input.
module smips_mc_ctrl
    import smips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
`ifdef SMIPS_MEM_WAIT_EN
    input  logic             mem_ready,
`endif
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [2:0]       alu_ctrl,
    output logic             alu_src,
    output logic             reg_dest,
    output logic             reg_write_enable,
    output logic             ram_write_enable,
    output logic             write_back_select,
    output logic [2:0]       state,
    output logic             retire,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instr_count
);

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_opcode;
    logic [5:0]       r_funct;
    logic             r_illegal;
    logic [CNT_W-1:0] r_count;

    logic [5:0] w_dec_funct;
    logic [2:0] w_dec_alu_ctrl;
    logic       w_funct_illegal;
    logic       w_mem_done;
    logic       w_is_r;
    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_is_addi;

    logic       w_ir_write;
    logic       w_pc_write;
    logic [1:0] w_pc_src;
    logic [2:0] w_alu_ctrl;
    logic       w_alu_src;
    logic       w_reg_dest;
    logic       w_reg_we;
    logic       w_ram_we;
    logic       w_wb_sel;
    logic       w_retire;

    // DECODE checks the live IR; later phases use the latched copy
    assign w_dec_funct = (r_state == S_DECODE) ? funct : r_funct;

    smips_alu_decoder u_alu_dec (
        .i_funct         (w_dec_funct),
        .o_alu_ctrl      (w_dec_alu_ctrl),
        .o_funct_illegal (w_funct_illegal)
    );

`ifdef SMIPS_MEM_WAIT_EN
    assign w_mem_done = mem_ready;
`else
    assign w_mem_done = 1'b1;
`endif

    assign w_is_r    = (r_opcode == OP_RTYPE);
    assign w_is_lw   = (r_opcode == OP_LW);
    assign w_is_sw   = (r_opcode == OP_SW);
    assign w_is_addi = (r_opcode == OP_ADDI);

    always_comb begin
        w_next     = r_state;
        w_ir_write = 1'b0;
        w_pc_write = 1'b0;
        w_pc_src   = PC_PLUS4;
        w_alu_ctrl = 3'b000;
        w_alu_src  = 1'b0;
        w_reg_dest = 1'b0;
        w_reg_we   = 1'b0;
        w_ram_we   = 1'b0;
        w_wb_sel   = 1'b0;
        w_retire   = 1'b0;
        if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
            w_alu_src  = !w_is_r;
            w_alu_ctrl = w_is_r ? w_dec_alu_ctrl : ALU_ADD;
        end
        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: w_next = w_funct_illegal ? S_HALT : S_EXEC;
                    OP_LW,
                    OP_SW,
                    OP_ADDI:  w_next = S_EXEC;
                    OP_BEQ:   w_next = S_BRANCH;
                    OP_J:     w_next = S_JUMP;
                    default:  w_next = S_HALT;
                endcase
            end
            S_EXEC: w_next = (w_is_r || w_is_addi) ? S_WB : S_MEM;
            S_MEM: begin
                w_ram_we = w_is_sw;
                if (w_mem_done) begin
                    w_retire = w_is_sw;
                    w_next   = w_is_sw ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                w_reg_we   = 1'b1;
                w_reg_dest = w_is_r;
                w_wb_sel   = w_is_lw;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_ctrl = ALU_SUB;
                w_pc_src   = PC_BRANCH;
                w_pc_write = alu_zero;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_JUMP: begin
                w_pc_src   = PC_JUMP;
                w_pc_write = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_HALT: w_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_opcode  <= 6'd0;
            r_funct   <= 6'd0;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_opcode <= opcode;
                r_funct  <= funct;
                if (w_next == S_HALT)
                    r_illegal <= 1'b1;
            end
            if (w_retire)
                r_count <= r_count + CNT_W'(1);
        end
    end

    // Reset forces every control output low without waiting for a clock
    assign ir_write          = rst_n & w_ir_write;
    assign pc_write          = rst_n & w_pc_write;
    assign pc_src            = rst_n ? w_pc_src : 2'b00;
    assign alu_ctrl          = rst_n ? w_alu_ctrl : 3'b000;
    assign alu_src           = rst_n & w_alu_src;
    assign reg_dest          = rst_n & w_reg_dest;
    assign reg_write_enable  = rst_n & w_reg_we;
    assign ram_write_enable  = rst_n & w_ram_we;
    assign write_back_select = rst_n & w_wb_sel;
    assign retire            = rst_n & w_retire;
    assign state             = r_state;
    assign illegal_instr     = r_illegal;
    assign instr_count       = r_count;

endmodule

// File: tb/tb_smips_mc_ctrl.sv
// Directed-vector bench for smips_mc_ctrl (counter narrowed to 4 bits
// so wrap-around is reachable).
module tb_smips_mc_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
`ifdef SMIPS_MEM_WAIT_EN
    logic       mem_ready;
`endif
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [2:0] alu_ctrl;
    logic       alu_src;
    logic       reg_dest;
    logic       reg_write_enable;
    logic       ram_write_enable;
    logic       write_back_select;
    logic [2:0] state;
    logic       retire;
    logic       illegal_instr;
    logic [3:0] instr_count;

    int n_vec;
    int n_err;
    int n_excl;

    int          t_lat;
    logic [31:0] t_seq;
    int          t_rwe;
    int          t_mwe;
    int          t_pcw;
    logic        t_done;
    logic        t_dest;
    logic        t_wbs;
    logic [2:0]  t_actl;
    logic        t_asrc;
    logic [1:0]  t_psrc;
    logic        t_pcwr;

    smips_mc_ctrl #(.CNT_W(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .opcode            (opcode),
        .funct             (funct),
        .alu_zero          (alu_zero),
`ifdef SMIPS_MEM_WAIT_EN
        .mem_ready         (mem_ready),
`endif
        .ir_write          (ir_write),
        .pc_write          (pc_write),
        .pc_src            (pc_src),
        .alu_ctrl          (alu_ctrl),
        .alu_src           (alu_src),
        .reg_dest          (reg_dest),
        .reg_write_enable  (reg_write_enable),
        .ram_write_enable  (ram_write_enable),
        .write_back_select (write_back_select),
        .state             (state),
        .retire            (retire),
        .illegal_instr     (illegal_instr),
        .instr_count       (instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting from a sampled FETCH cycle
    task automatic run(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int wait_n);
        int waited;
        waited = 0;
        opcode = op;
        funct = fn;
        alu_zero = z;
        t_lat = 0;
        t_seq = 0;
        t_rwe = 0;
        t_mwe = 0;
        t_pcw = 0;
        t_done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            t_lat++;
            t_seq = {t_seq[28:0], state};
            t_rwe += int'(reg_write_enable);
            t_mwe += int'(ram_write_enable);
            if (state != 3'd0) begin
                t_pcw += int'(pc_write);
                if (int'(reg_write_enable) + int'(ram_write_enable)
                    + int'(pc_write) > 1)
                    n_excl++;
            end
            if (retire) begin
                t_done = 1'b1;
                t_dest = reg_dest;
                t_wbs  = write_back_select;
                t_actl = alu_ctrl;
                t_asrc = alu_src;
                t_psrc = pc_src;
                t_pcwr = pc_write;
                break;
            end
`ifdef SMIPS_MEM_WAIT_EN
            if (state == 3'd3 && waited < wait_n) begin
                mem_ready = 1'b0;
                waited++;
            end else begin
                mem_ready = 1'b1;
            end
`else
            waited += wait_n;
`endif
            step();
        end
        chk("retired", 32'(t_done), 32'd1);
        step();
    endtask

    initial begin
        int en_cnt;
        n_vec = 0;
        n_err = 0;
        n_excl = 0;
        rst_n = 1'b0;
        opcode = 6'd0;
        funct = 6'd0;
        alu_zero = 1'b0;
`ifdef SMIPS_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        #12;
        chk("rst_ir_write", 32'(ir_write), 32'd0);
        chk("rst_pc_write", 32'(pc_write), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_illegal", 32'(illegal_instr), 32'd0);
        #5;
        rst_n = 1'b1;
        #1;
        chk("fetch_ir_write", 32'(ir_write), 32'd1);
        chk("fetch_pc_write", 32'(pc_write), 32'd1);

        run(6'b000000, 6'b100000, 1'b0, 0);
        chk("add_seq", t_seq, 32'({3'd0, 3'd1, 3'd2, 3'd4}));
        chk("add_lat", 32'(t_lat), 32'd4);
        chk("add_rwe", 32'(t_rwe), 32'd1);
        chk("add_dest", 32'(t_dest), 32'd1);
        chk("add_actl", 32'(t_actl), 32'b010);
        chk("add_asrc", 32'(t_asrc), 32'd0);
        chk("add_count", 32'(instr_count), 32'd1);

        run(6'b100011, 6'd0, 1'b0, 0);
        chk("lw_seq", t_seq, 32'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4}));
        chk("lw_lat", 32'(t_lat), 32'd5);
        chk("lw_wbs", 32'(t_wbs), 32'd1);
        chk("lw_dest", 32'(t_dest), 32'd0);
        chk("lw_asrc", 32'(t_asrc), 32'd1);

        run(6'b101011, 6'd0, 1'b0, 0);
        chk("sw_lat", 32'(t_lat), 32'd4);
        chk("sw_mwe", 32'(t_mwe), 32'd1);
        chk("sw_rwe", 32'(t_rwe), 32'd0);
        chk("sw_actl", 32'(t_actl), 32'b010);

        run(6'b000100, 6'd0, 1'b1, 0);
        chk("beq1_lat", 32'(t_lat), 32'd3);
        chk("beq1_pcw", 32'(t_pcwr), 32'd1);
        chk("beq1_psrc", 32'(t_psrc), 32'b01);
        chk("beq1_actl", 32'(t_actl), 32'b110);

        run(6'b000100, 6'd0, 1'b0, 0);
        chk("beq0_lat", 32'(t_lat), 32'd3);
        chk("beq0_pcw", 32'(t_pcw), 32'd0);

        run(6'b000010, 6'd0, 1'b0, 0);
        chk("j_lat", 32'(t_lat), 32'd3);
        chk("j_psrc", 32'(t_psrc), 32'b10);
        chk("j_pcw", 32'(t_pcwr), 32'd1);

        run(6'b000000, 6'b100010, 1'b0, 0);
        chk("sub_actl", 32'(t_actl), 32'b110);
        run(6'b000000, 6'b100100, 1'b0, 0);
        chk("and_actl", 32'(t_actl), 32'b000);
        run(6'b000000, 6'b100101, 1'b0, 0);
        chk("or_actl", 32'(t_actl), 32'b001);
        run(6'b000000, 6'b101010, 1'b0, 0);
        chk("slt_actl", 32'(t_actl), 32'b111);

        run(6'b001000, 6'd0, 1'b0, 0);
        chk("addi_lat", 32'(t_lat), 32'd4);
        chk("addi_dest", 32'(t_dest), 32'd0);
        chk("addi_asrc", 32'(t_asrc), 32'd1);
        chk("addi_wbs", 32'(t_wbs), 32'd0);
        chk("count_11", 32'(instr_count), 32'd11);

        opcode = 6'b101011;
        step();
        step();
        step();
        chk("sw_mem_state", 32'(state), 32'd3);
        chk("sw_mem_mwe", 32'(ram_write_enable), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mwe", 32'(ram_write_enable), 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_count", 32'(instr_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        opcode = 6'b111111;
        step();
        step();
        chk("halt_state", 32'(state), 32'd7);
        chk("halt_illegal", 32'(illegal_instr), 32'd1);
        en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            en_cnt += int'(ir_write) + int'(pc_write) + int'(retire)
                    + int'(reg_write_enable) + int'(ram_write_enable);
            step();
        end
        chk("halt_quiet", 32'(en_cnt), 32'd0);
        chk("halt_sticky", 32'(illegal_instr), 32'd1);
        chk("halt_stays", 32'(state), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("halt_rst_state", 32'(state), 32'd0);
        chk("halt_rst_illegal", 32'(illegal_instr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        opcode = 6'b000000;
        funct = 6'b000001;
        step();
        step();
        chk("badfn_state", 32'(state), 32'd7);
        chk("badfn_illegal", 32'(illegal_instr), 32'd1);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 15; i++)
            run(6'b000010, 6'd0, 1'b0, 0);
        chk("count_15", 32'(instr_count), 32'd15);
        run(6'b000010, 6'd0, 1'b0, 0);
        chk("count_wrap", 32'(instr_count), 32'd0);

`ifdef SMIPS_MEM_WAIT_EN
        run(6'b100011, 6'd0, 1'b0, 3);
        chk("lw_wait_seq", t_seq,
            32'({3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4}));
        chk("lw_wait_lat", 32'(t_lat), 32'd8);
        chk("lw_wait_count", 32'(instr_count), 32'd1);
`endif

        chk("one_hot_enables", 32'(n_excl), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
